// File: rtl/cipher_ctrl_pkg.sv
// rtl/cipher_ctrl_pkg.sv - shared state encoding and key width for the cipher key sequencer
package cipher_ctrl_pkg;

  localparam int KEY_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/key_piso_serializer.sv
// rtl/key_piso_serializer.sv - key shadow register and bit counter presenting the key MSB first
module key_piso_serializer
  import cipher_ctrl_pkg::*;
#(
  parameter int M     = KEY_W,
  parameter int CNT_W = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [M-1:0] i_key,
  input  logic         i_adv,
  output logic         o_bit,
  output logic         o_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [M-1:0]     r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_shadow <= i_key;
      r_cnt    <= '0;
    end else if (i_adv) begin
      // Wrap explicitly so a second pass replays the same bit order for any M.
      r_cnt <= o_last ? '0 : r_cnt + ONE_CNT;
    end
  end

  assign w_idx  = LAST_CNT - r_cnt;
  assign o_bit  = r_shadow[w_idx];
  assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/xor_cipher_key_sequencer.sv
// rtl/xor_cipher_key_sequencer.sv - loads a parallel key into the XOR cipher config chain and gates its enables
// Optional readback verify pass and error state: CIPHER_KEY_VERIFY_EN.
module xor_cipher_key_sequencer
  import cipher_ctrl_pkg::*;
#(
  parameter int M     = KEY_W,
  parameter int CNT_W = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] key_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic         tx_req_i,
  input  logic         rx_req_i,
  output logic         cfg_en_o,
  output logic         cfg_bit_o,
  input  logic         cfg_o_i,
  output logic         tx_en_o,
  output logic         rx_en_o,
  output logic         key_loaded_o,
  output logic         busy_o,
  output logic         err_o,
  input  logic         err_clr_i
);

  state_t r_state;
  logic   w_accept;
  logic   w_bit;
  logic   w_last;
  logic   w_run;
  logic   w_shift;

  key_piso_serializer #(
    .M     (M),
    .CNT_W (CNT_W)
  ) u_piso (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_key  (key_i),
    .i_adv  (w_shift),
    .o_bit  (w_bit),
    .o_last (w_last)
  );

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = key_valid_i & key_ready_o;

`ifdef CIPHER_KEY_VERIFY_EN
  logic r_mis;
  logic w_mismatch;

  assign w_mismatch = (r_state == ST_VERIFY) & (cfg_o_i != w_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mis   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_accept) begin
            r_state <= ST_LOAD;
            r_mis   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_last) r_state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (w_mismatch) r_mis <= 1'b1;
          // The final bit's comparison is folded in directly; r_mis only sees it next cycle.
          if (w_last) r_state <= (r_mis | w_mismatch) ? ST_ERROR : ST_RUN;
        end
        ST_ERROR: begin
          if (err_clr_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_shift = (r_state == ST_LOAD) | (r_state == ST_VERIFY);
  assign err_o   = (r_state == ST_ERROR);
`else
  logic w_unused;

  assign w_unused = err_clr_i ^ cfg_o_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_accept) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (w_last) r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_shift = (r_state == ST_LOAD);
  assign err_o   = 1'b0;
`endif

  // Held low while rst is asserted so every output reads zero during reset.
  assign key_ready_o  = ~rst & ((r_state == ST_IDLE) | w_run);
  assign cfg_en_o     = w_shift;
  assign cfg_bit_o    = w_shift & w_bit;
  assign busy_o       = w_shift;
  assign key_loaded_o = w_run;
  assign tx_en_o      = tx_req_i & w_run;
  assign rx_en_o      = rx_req_i & w_run;

endmodule

// File: doc/xor_cipher_key_sequencer.md
Name: xor_cipher_key_sequencer

Overview:
- Controller in front of the dual XOR stream cipher (M-bit key).
- Accepts a parallel key over a valid/ready handshake and serialises it into the cipher's config shift chain (cfg_en/cfg_i).
- Holds the cipher's tx/rx enables low while a key is loading; releases them only once a key is resident.
- Arbitrates tx/rx enable requests against re-key events.

Parameters:
- M, 32, key length in bits; equals the cipher config chain depth.
- CNT_W, $clog2(M), width of the bit counter; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- key_i  in  M  key word; bit M-1 is shifted first
- key_valid_i  in  1  key offered
- key_ready_o  out  1  key accepted when valid&ready at posedge
- tx_req_i  in  1  user request to run the TX stream
- rx_req_i  in  1  user request to run the RX stream
- cfg_en_o  out  1  to cipher cfg_en; chain shifts on each posedge while high
- cfg_bit_o  out  1  to cipher cfg_i; serial key bit
- cfg_o_i  in  1  from cipher cfg_o; tail of the config chain
- tx_en_o  out  1  to cipher tx_en
- rx_en_o  out  1  to cipher rx_en
- key_loaded_o  out  1  a valid key is resident in the cipher
- busy_o  out  1  state is LOAD or VERIFY
- err_o  out  1  readback mismatch latched
- err_clr_i  in  1  clears err_o; leaves ERROR

Behaviour:
- State machine states: IDLE, LOAD, VERIFY, RUN, ERROR. State, counter and key shadow register are flops; all are cleared by rst.
- Reset values:
  - state = IDLE
  - key_loaded_o = 0, err_o = 0, cfg_en_o = 0, cfg_bit_o = 0
  - tx_en_o = 0, rx_en_o = 0, busy_o = 0
- key_ready_o = 1 in IDLE and RUN; 0 in LOAD, VERIFY and ERROR.
- Handshake acceptance in IDLE or RUN:
  - key_i is latched into the shadow register and the counter is cleared.
  - Next state is LOAD.
  - key_loaded_o goes to 0 on the same edge.
- A new key offered during RUN has priority over running: tx_en_o and rx_en_o drop in the cycle after acceptance.
- LOAD:
  - cfg_en_o = 1 for exactly M consecutive cycles.
  - cfg_bit_o = shadow[M-1-cnt].
  - cnt increments each cycle.
  - At cnt == M-1 the counter wraps to 0 and the state advances to VERIFY (feature enabled) or RUN (feature disabled).
- VERIFY (feature enabled only):
  - Second pass of M cycles: cfg_en_o = 1, cfg_bit_o = shadow[M-1-cnt], so the chain content is unchanged after the pass.
  - cfg_o_i is compared each cycle against shadow[M-1-cnt].
  - Any mismatch sets a sticky mismatch flag.
  - At cnt == M-1: next state is ERROR if (flag | mismatch this cycle), otherwise RUN.
- RUN:
  - key_loaded_o = 1.
  - tx_en_o = tx_req_i; rx_en_o = rx_req_i. This is a combinational AND with (state == RUN); there is no other gating.
- ERROR:
  - err_o = 1, key_loaded_o = 0, all enables low, key_ready_o = 0.
  - err_clr_i = 1 moves to IDLE next cycle and clears err_o.
- busy_o = 1 in LOAD and VERIFY.
- Latency from acceptance edge to first RUN cycle: M+1 cycles (feature disabled); 2M+1 cycles (feature enabled).
- cfg_en_o is never high outside LOAD/VERIFY. cfg_bit_o = 0 whenever cfg_en_o = 0.
- Reset asserted mid-load returns to IDLE immediately with key_loaded_o = 0. The cipher chain contents are then undefined, and a fresh key must be loaded.
- key_valid_i asserted while busy is ignored and is not queued.
- tx_req_i/rx_req_i asserted outside RUN have no effect.

Optional Feature:
- Macro: CIPHER_KEY_VERIFY_EN.
- Defined: the VERIFY state exists, readback comparison is performed, and err_o / err_clr_i are functional.
- Undefined:
  - LOAD goes directly to RUN.
  - err_o is tied to 0.
  - err_clr_i and cfg_o_i are unused.
  - The ERROR state is never entered.

Decomposition:
- Package cipher_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, VERIFY, RUN, ERROR);
  - the default key width constant KEY_W = 32.
- Sub-module key_piso_serializer: M-bit shadow register, CNT_W counter, and a last-bit flag (cnt == M-1). It is instantiated once and used by both the LOAD and VERIFY passes.

Test Plan:
- After reset, key_i = 32'hA5C3_0F96, valid = 1 for 1 cycle:
  - cfg_en_o is high for exactly 32 cycles;
  - the cfg_bit_o sequence is 1,0,1,0,0,1,0,1,... (MSB first);
  - with tx_req = rx_req = 1, tx_en_o and rx_en_o rise at cycle 33 (feature disabled) or cycle 65 (feature enabled);
  - key_loaded_o = 1.
- Feature enabled, cipher chain model connected, key 32'hDEAD_BEEF: VERIFY passes, RUN is reached, err_o stays 0, and the chain holds 32'hDEAD_BEEF afterward.
- Feature enabled, cfg_o_i bit 7 of the second pass forced inverted: ERROR at cycle 65, err_o = 1, enables 0, key_ready_o = 0. Pulsing err_clr_i gives IDLE and key_ready_o = 1 the next cycle.
- In RUN with tx_req = 1, offer key 32'h1234_5678:
  - tx_en_o falls the cycle after acceptance;
  - key_loaded_o goes to 0;
  - tx_en_o resumes after reload.
- key_valid_i held high during LOAD: no second acceptance; exactly 32 (or 64) cfg_en_o cycles.
- rst asserted at LOAD cycle 10: all outputs are zero asynchronously; after release, state is IDLE, key_ready_o = 1, key_loaded_o = 0.
